// File: rtl/upower_decode_execute.sv
// rtl/upower_decode_execute.sv - Power ISA field decode plus 64-bit ALU execute, one registered stage
module upower_decode_execute (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    input  logic [63:0] operand_a,
    input  logic [63:0] operand_b,
    input  logic        alu_src,
    input  logic [1:0]  alu_op,
    output logic [5:0]  po,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  bo,
    output logic [4:0]  bi,
    output logic        aa,
    output logic        lk,
    output logic        rc,
    output logic        oe,
    output logic [9:0]  xox,
    output logic [8:0]  xoxo,
    output logic [15:0] si,
    output logic [13:0] bd,
    output logic [63:0] ds,
    output logic [1:0]  xods,
    output logic [23:0] li,
    output logic        out_valid,
    output logic [3:0]  alu_ctrl,
    output logic [63:0] alu_result,
    output logic        flag
);

    localparam logic [3:0] CTRL_AND   = 4'd0;
    localparam logic [3:0] CTRL_OR    = 4'd1;
    localparam logic [3:0] CTRL_ADD   = 4'd2;
    localparam logic [3:0] CTRL_XOR   = 4'd3;
    localparam logic [3:0] CTRL_NAND  = 4'd4;
    localparam logic [3:0] CTRL_NOR   = 4'd5;
    localparam logic [3:0] CTRL_SUB   = 4'd6;
    localparam logic [3:0] CTRL_EXTSW = 4'd7;
    localparam logic [3:0] CTRL_SLD   = 4'd8;
    localparam logic [3:0] CTRL_SRD   = 4'd9;
    localparam logic [3:0] CTRL_SRAD  = 4'd10;

    logic [9:0]  dec_xox;
    logic [8:0]  dec_xoxo;
    logic [5:0]  dec_po;
    logic [63:0] dec_ds;
    logic [63:0] imm;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [3:0]  next_ctrl;
    logic [63:0] next_result;
    logic [6:0]  shamt;

    assign dec_po   = instruction[31:26];
    assign dec_xox  = instruction[10:1];
    assign dec_xoxo = instruction[9:1];
    assign dec_ds   = {{48{instruction[15]}}, instruction[15:2], 2'b00};

    // DS-form opcodes (ld/std families) use the word-aligned displacement
    assign imm  = (dec_po == 6'd58 || dec_po == 6'd62) ? dec_ds
                                                        : {{48{instruction[15]}}, instruction[15:0]};
    assign op_a = operand_a;
    assign op_b = alu_src ? imm : operand_b;
    assign shamt = op_b[6:0];

    always_comb begin
        next_ctrl = CTRL_ADD;
        case (alu_op)
            2'b00: next_ctrl = CTRL_ADD;
            2'b01: next_ctrl = CTRL_SUB;
            2'b11: next_ctrl = CTRL_OR;
            default: begin
                // XO-form (xoxo) is only consulted when the X-form field has no match
                case (dec_xox)
                    10'd28:  next_ctrl = CTRL_AND;
                    10'd444: next_ctrl = CTRL_OR;
                    10'd316: next_ctrl = CTRL_XOR;
                    10'd476: next_ctrl = CTRL_NAND;
                    10'd124: next_ctrl = CTRL_NOR;
                    10'd986: next_ctrl = CTRL_EXTSW;
                    10'd27:  next_ctrl = CTRL_SLD;
                    10'd539: next_ctrl = CTRL_SRD;
                    10'd794: next_ctrl = CTRL_SRAD;
                    default: begin
                        case (dec_xoxo)
                            9'd266:  next_ctrl = CTRL_ADD;
                            9'd40:   next_ctrl = CTRL_SUB;
                            default: next_ctrl = CTRL_ADD;
                        endcase
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        next_result = op_a + op_b;
        case (next_ctrl)
            CTRL_AND:   next_result = op_a & op_b;
            CTRL_OR:    next_result = op_a | op_b;
            CTRL_ADD:   next_result = op_a + op_b;
            CTRL_XOR:   next_result = op_a ^ op_b;
            CTRL_NAND:  next_result = ~(op_a & op_b);
            CTRL_NOR:   next_result = ~(op_a | op_b);
            CTRL_SUB:   next_result = op_a - op_b;
            CTRL_EXTSW: next_result = {{32{op_a[31]}}, op_a[31:0]};
            CTRL_SLD:   next_result = shamt[6] ? 64'd0 : (op_a << shamt[5:0]);
            CTRL_SRD:   next_result = shamt[6] ? 64'd0 : (op_a >> shamt[5:0]);
            CTRL_SRAD:  next_result = shamt[6] ? {64{op_a[63]}}
                                               : 64'($signed(op_a) >>> shamt[5:0]);
            default:    next_result = op_a + op_b;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            po         <= '0;
            rs         <= '0;
            rt         <= '0;
            rd         <= '0;
            bo         <= '0;
            bi         <= '0;
            aa         <= 1'b0;
            lk         <= 1'b0;
            rc         <= 1'b0;
            oe         <= 1'b0;
            xox        <= '0;
            xoxo       <= '0;
            si         <= '0;
            bd         <= '0;
            ds         <= '0;
            xods       <= '0;
            li         <= '0;
            out_valid  <= 1'b0;
            alu_ctrl   <= '0;
            alu_result <= '0;
            flag       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                po         <= dec_po;
                rs         <= instruction[25:21];
                bo         <= instruction[25:21];
                rt         <= instruction[20:16];
                bi         <= instruction[20:16];
                rd         <= instruction[15:11];
                oe         <= instruction[10];
                xox        <= dec_xox;
                xoxo       <= dec_xoxo;
                rc         <= instruction[0];
                lk         <= instruction[0];
                aa         <= instruction[1];
                si         <= instruction[15:0];
                bd         <= instruction[15:2];
                li         <= instruction[25:2];
                xods       <= instruction[1:0];
                ds         <= dec_ds;
                alu_ctrl   <= next_ctrl;
                alu_result <= next_result;
                flag       <= (next_result == 64'd0);
            end
        end
    end

endmodule

// File: tb/tb_upower_decode_execute.sv
// tb/tb_upower_decode_execute.sv - directed vector bench for upower_decode_execute
module tb_upower_decode_execute;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  po;
    logic [4:0]  rs, rt, rd, bo, bi;
    logic        aa, lk, rc, oe;
    logic [9:0]  xox;
    logic [8:0]  xoxo;
    logic [15:0] si;
    logic [13:0] bd;
    logic [63:0] ds;
    logic [1:0]  xods;
    logic [23:0] li;
    logic        out_valid;
    logic [3:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic        flag;

    int errors = 0;
    int checks = 0;

    upower_decode_execute dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .instruction(instruction), .operand_a(operand_a), .operand_b(operand_b),
        .alu_src(alu_src), .alu_op(alu_op),
        .po(po), .rs(rs), .rt(rt), .rd(rd), .bo(bo), .bi(bi),
        .aa(aa), .lk(lk), .rc(rc), .oe(oe), .xox(xox), .xoxo(xoxo),
        .si(si), .bd(bd), .ds(ds), .xods(xods), .li(li),
        .out_valid(out_valid), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .flag(flag)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic        src;
        logic [1:0]  op;
        logic [3:0]  exp_ctrl;
        logic [63:0] exp_result;
        logic        exp_flag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] a,
                         input logic [63:0] b, input logic s, input logic [1:0] o);
        in_valid = v; instruction = i; operand_a = a; operand_b = b; alu_src = s; alu_op = o;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs.push_back('{"add_xo",   32'h7C000214, 64'd5, 64'd7, 1'b0, 2'b10, 4'd2, 64'd12, 1'b0});
        vecs.push_back('{"addi_neg", 32'h3800FFFF, 64'd10, 64'd0, 1'b1, 2'b00, 4'd2, 64'd9, 1'b0});
        vecs.push_back('{"sub_op01", 32'h00000000, 64'h1234, 64'h1234, 1'b0, 2'b01, 4'd6, 64'd0, 1'b1});
        vecs.push_back('{"srad_4",   32'h7C000634, 64'h8000000000000000, 64'd4, 1'b0, 2'b10, 4'd10, 64'hF800000000000000, 1'b0});
        vecs.push_back('{"srad_64",  32'h7C000634, 64'h8000000000000000, 64'd64, 1'b0, 2'b10, 4'd10, 64'hFFFFFFFFFFFFFFFF, 1'b0});
        vecs.push_back('{"ld_ds",    32'hE800FFF8, 64'h100, 64'd0, 1'b1, 2'b00, 4'd2, 64'hF8, 1'b0});
        vecs.push_back('{"and",      32'h7C000038, 64'hF0F0, 64'hFF00, 1'b0, 2'b10, 4'd0, 64'hF000, 1'b0});
        vecs.push_back('{"or_op11",  32'h00000000, 64'h0F, 64'hF0, 1'b0, 2'b11, 4'd1, 64'hFF, 1'b0});
        vecs.push_back('{"xor",      32'h7C000278, 64'hFF, 64'h0F, 1'b0, 2'b10, 4'd3, 64'hF0, 1'b0});
        vecs.push_back('{"nand",     32'h7C0003B8, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2'b10, 4'd4, 64'd0, 1'b1});
        vecs.push_back('{"nor",      32'h7C0000F8, 64'd0, 64'd0, 1'b0, 2'b10, 4'd5, 64'hFFFFFFFFFFFFFFFF, 1'b0});
        vecs.push_back('{"subf",     32'h7C000050, 64'd3, 64'd5, 1'b0, 2'b10, 4'd6, 64'hFFFFFFFFFFFFFFFE, 1'b0});
        vecs.push_back('{"extsw",    32'h7C0007B4, 64'h0000000080000000, 64'd0, 1'b0, 2'b10, 4'd7, 64'hFFFFFFFF80000000, 1'b0});
        vecs.push_back('{"sld_63",   32'h7C000036, 64'd1, 64'd63, 1'b0, 2'b10, 4'd8, 64'h8000000000000000, 1'b0});
        vecs.push_back('{"sld_64",   32'h7C000036, 64'd1, 64'd64, 1'b0, 2'b10, 4'd8, 64'd0, 1'b1});
        vecs.push_back('{"srd_4",    32'h7C000436, 64'h8000000000000000, 64'd4, 1'b0, 2'b10, 4'd9, 64'h0800000000000000, 1'b0});
        vecs.push_back('{"unknown",  32'h7C000000, 64'd1, 64'd2, 1'b0, 2'b10, 4'd2, 64'd3, 1'b0});
        vecs.push_back('{"addo_oe",  32'h7C000614, 64'd1, 64'd1, 1'b0, 2'b10, 4'd2, 64'd2, 1'b0});
        vecs.push_back('{"add_wrap", 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 2'b00, 4'd2, 64'd0, 1'b1});

        reset_n = 1'b0;
        drive(1'b1, 32'h7C000214, 64'd5, 64'd7, 1'b0, 2'b10);
        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", alu_result, 64'd0);
        chk("rst_flag", 64'(flag), 64'd0);
        chk("rst_po", 64'(po), 64'd0);
        chk("rst_ds", ds, 64'd0);
        chk("rst_li", 64'(li), 64'd0);

        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].op);
            step();
            chk({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
            chk({vecs[i].name, "_ctrl"}, 64'(alu_ctrl), 64'(vecs[i].exp_ctrl));
            chk({vecs[i].name, "_result"}, alu_result, vecs[i].exp_result);
            chk({vecs[i].name, "_flag"}, 64'(flag), 64'(vecs[i].exp_flag));
            chk({vecs[i].name, "_po"}, 64'(po), 64'(vecs[i].instr >> 26));
            chk({vecs[i].name, "_xox"}, 64'(xox), 64'((vecs[i].instr >> 1) & 32'h3FF));
            chk({vecs[i].name, "_xoxo"}, 64'(xoxo), 64'((vecs[i].instr >> 1) & 32'h1FF));
            @(negedge clock);
        end

        drive(1'b1, 32'h7C000214, 64'd5, 64'd7, 1'b0, 2'b10);
        step();
        chk("add_po", 64'(po), 64'd31);
        chk("add_xoxo", 64'(xoxo), 64'd266);
        chk("add_result", alu_result, 64'd12);
        @(negedge clock);
        drive(1'b1, 32'h3800FFFF, 64'd10, 64'd0, 1'b1, 2'b00);
        step();
        chk("addi_si", 64'(si), 64'hFFFF);
        chk("addi_po", 64'(po), 64'd14);
        @(negedge clock);
        drive(1'b1, 32'hE800FFF8, 64'h100, 64'd0, 1'b1, 2'b00);
        step();
        chk("ld_ds_val", ds, 64'hFFFFFFFFFFFFFFF8);
        chk("ld_xods", 64'(xods), 64'd0);
        chk("ld_bd", 64'(bd), 64'h3FFE);

        @(negedge clock);
        drive(1'b0, 32'h7C000036, 64'd0, 64'd0, 1'b0, 2'b01);
        step();
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_result_hold", alu_result, 64'hF8);
        chk("idle_ds_hold", ds, 64'hFFFFFFFFFFFFFFF8);
        chk("idle_ctrl_hold", 64'(alu_ctrl), 64'd2);
        chk("idle_po_hold", 64'(po), 64'd58);

        @(negedge clock);
        reset_n = 1'b0;
        drive(1'b1, 32'h7C000634, 64'h8000000000000000, 64'd4, 1'b0, 2'b10);
        step();
        chk("rst2_valid", 64'(out_valid), 64'd0);
        chk("rst2_result", alu_result, 64'd0);
        chk("rst2_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst2_po", 64'(po), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_result", alu_result, 64'hF800000000000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upower_decode_execute.md
UPOWER_DECODE_EXECUTE -- requirements
Module: upower_decode_execute

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named clock (input, 1, all state updates on posedge) and reset_n (input, 1, synchronous active-low).
REQ-002 Inputs SHALL be:
- in_valid (1): instruction/operands valid this cycle.
- instruction (32): bit 31 = ISA bit 0.
- operand_a, operand_b (64 each): register operands.
- alu_src (1): 1 selects the immediate as B.
- alu_op (2): operation class.
REQ-003 Decode outputs SHALL be:
- po (6), rs (5), rt (5), rd (5), bo (5), bi (5), aa (1), lk (1), rc (1), oe (1).
- xox (10), xoxo (9), si (16), bd (14), ds (64), xods (2), li (24).
REQ-004 Execute outputs SHALL be out_valid (1), alu_ctrl (4), alu_result (64) and flag (1, zero flag).

Function
REQ-005 Field extraction SHALL be:
- po=[31:26], rs=bo=[25:21], rt=bi=[20:16], rd=[15:11].
- oe=[10], xox=[10:1], xoxo=[9:1], rc=lk=[0], aa=[1].
- si=[15:0], bd=[15:2], li=[25:2], xods=[1:0].
REQ-006 ds SHALL equal the sign extension to 64 bits of {instruction[15:2],2'b00}.
REQ-007 The immediate SHALL be ds when po is 58 or 62, else si sign-extended to 64 bits; B = alu_src ? immediate : operand_b; A = operand_a.
REQ-008 alu_ctrl codes SHALL be: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NAND, 5 NOR, 6 SUB (A−B), 7 EXTSW, 8 SLD, 9 SRD, 10 SRAD; codes 11-15 are unused and SHALL produce ADD.
REQ-009 alu_op SHALL map as: 00 ADD; 01 SUB; 11 OR; 10 decode from the function fields (REQ-010).
REQ-010 With alu_op=10, xox is matched first:
- 28 AND, 444 OR, 316 XOR, 476 NAND, 124 NOR.
- 986 EXTSW, 27 SLD, 539 SRD, 794 SRAD.
- With no xox match, xoxo is matched: 266 ADD, 40 SUB.
- Anything else SHALL produce ADD.
REQ-011 Arithmetic SHALL be 64-bit, two's complement, wrapping modulo 2^64, with no carry/overflow outputs.
REQ-012 EXTSW SHALL sign-extend A[31:0]; B is ignored.
REQ-013 Shifts SHALL use amount B[6:0] applied to A:
- B[6]=1: SLD and SRD give 0; SRAD gives 64 copies of A[63].
- Otherwise: shift by B[5:0]; SRAD fills with A[63].
REQ-014 flag SHALL be 1 exactly when the registered alu_result equals 0.
REQ-015 Outputs SHALL be registered, with latency of one cycle:
- On a posedge with in_valid=1, all outputs update from that cycle's inputs and out_valid=1.
- With in_valid=0, out_valid=0 and every other output holds its value.
REQ-016 Back-to-back valid inputs SHALL be accepted every cycle with no stall; there is no backpressure.

Reset
REQ-017 While reset_n=0 at a posedge, every output, including out_valid and flag, SHALL become 0, and reset SHALL take priority over in_valid.
REQ-018 The first valid input after reset_n returns high SHALL produce out_valid=1 on the next posedge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- instruction=0x7C000214 (add), A=5, B=7, alu_op=10, alu_src=0 -> next cycle: alu_ctrl=2, alu_result=12, flag=0, po=31, xoxo=266, out_valid=1.
- instruction=0x3800FFFF (po=14), A=10, alu_src=1, alu_op=00 -> alu_result=9, si=0xFFFF.
- alu_op=01, A=B=0x1234 -> alu_result=0, flag=1.
- instruction=0x7C000634 (xox=794 SRAD), alu_op=10, A=0x8000000000000000, B=4 -> alu_result=0xF800000000000000; with B=64 -> 0xFFFFFFFFFFFFFFFF.
- instruction=0xE800FFF8 (po=58), alu_src=1, alu_op=00, A=0x100 -> ds=0xFFFFFFFFFFFFFFF8, xods=0, alu_result=0xF8.
- reset_n=0 while in_valid=1 -> all outputs 0 next posedge; in_valid=0 for one cycle -> out_valid=0 and the other outputs hold.
